// File: rtl/parking_pkg.sv
// Shared encodings and constants for the parking meter session controller.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CALC = 2'd2,
        ST_SHOW = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PH_DIV60  = 2'd0,
        PH_MUL    = 2'd1,
        PH_DIV100 = 2'd2
    } phase_t;

    localparam logic [16:0] SEC_PER_MIN = 17'd60;
    localparam logic [16:0] CENT_DIV    = 17'd100;

    localparam logic [4:0] HOUR_DAY  = 5'd8;
    localparam logic [4:0] HOUR_PEAK = 5'd13;
    localparam logic [4:0] HOUR_EVE  = 5'd18;
    localparam logic [4:0] HOUR_END  = 5'd24;

    // Location 000 is the premium zone; all other locations share one table.
    localparam logic [7:0] RATE_L0_NIGHT = 8'd145;
    localparam logic [7:0] RATE_L0_DAY   = 8'd167;
    localparam logic [7:0] RATE_L0_PEAK  = 8'd189;
    localparam logic [7:0] RATE_L0_EVE   = 8'd145;
    localparam logic [7:0] RATE_LX_NIGHT = 8'd134;
    localparam logic [7:0] RATE_LX_DAY   = 8'd156;
    localparam logic [7:0] RATE_LX_PEAK  = 8'd178;
    localparam logic [7:0] RATE_LX_EVE   = 8'd156;

    function automatic logic hour_valid(input logic [4:0] hour);
        return hour < HOUR_END;
    endfunction

endpackage

// File: rtl/parking_rate_lut.sv
// Rate lookup in cents-per-minute x100 from latched location and hour; 0 for an invalid hour.
module parking_rate_lut
    import parking_pkg::*;
(
    input  logic [2:0] location,
    input  logic [4:0] hour,
    output logic [7:0] rate_x100
);

    logic premium;

    assign premium = (location == 3'd0);

    always_comb begin
        rate_x100 = 8'd0;
        if (hour < HOUR_DAY)
            rate_x100 = premium ? RATE_L0_NIGHT : RATE_LX_NIGHT;
        else if (hour < HOUR_PEAK)
            rate_x100 = premium ? RATE_L0_DAY : RATE_LX_DAY;
        else if (hour < HOUR_EVE)
            rate_x100 = premium ? RATE_L0_PEAK : RATE_LX_PEAK;
        else if (hour < HOUR_END)
            rate_x100 = premium ? RATE_L0_EVE : RATE_LX_EVE;
    end

endmodule

// File: rtl/parking_session_ctrl.sv
// Parking session controller: times a session from the 1 Hz tick and computes
// its cost by sequential division/multiply once the session is stopped.
//
// state   | meaning
// IDLE    | waiting for a start with a valid hour
// RUN     | session active, sec_count advances on tick_1hz
// CALC    | DIV60 -> MUL -> DIV100 cost pipeline, busy high
// SHOW    | cost held and valid until clear or a new start
module parking_session_ctrl
    import parking_pkg::*;
#(
    parameter logic [11:0] SEC_MAX  = 12'd4095,
    parameter logic [13:0] COST_MAX = 14'd9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic [7:0]  sw,
    output logic [11:0] sec_count,
    output logic [13:0] cost,
    output logic        cost_valid,
    output logic        running,
    output logic        busy,
    output logic        hour_err
);

    state_t      state, state_n;
    phase_t      phase, phase_n;
    logic [11:0] sec_n;
    logic [16:0] work, work_n;
    logic [7:0]  quot, quot_n;
    logic [6:0]  min_q, min_n;
    logic [16:0] prod, prod_n;
    logic [13:0] cost_n;
    logic        err_n;
    logic [2:0]  loc, loc_n;
    logic [4:0]  hour, hour_n;
    logic [7:0]  rate_x100;
    logic [7:0]  cents;

    parking_rate_lut u_rate (
        .location  (loc),
        .hour      (hour),
        .rate_x100 (rate_x100)
    );

    assign running    = (state == ST_RUN);
    assign busy       = (state == ST_CALC);
    assign cost_valid = (state == ST_SHOW);

    always_comb begin
        state_n = state;
        phase_n = phase;
        sec_n   = sec_count;
        work_n  = work;
        quot_n  = quot;
        min_n   = min_q;
        prod_n  = prod;
        cost_n  = cost;
        err_n   = hour_err;
        loc_n   = loc;
        hour_n  = hour;
        // Ceiling quotient: any leftover remainder bills one more unit.
        cents   = quot + {7'd0, (work != 17'd0)};

        case (state)
            ST_IDLE, ST_SHOW: begin
                if (start) begin
                    if (hour_valid(sw[4:0])) begin
                        state_n = ST_RUN;
                        loc_n   = sw[7:5];
                        hour_n  = sw[4:0];
                        sec_n   = 12'd0;
                        cost_n  = 14'd0;
                        err_n   = 1'b0;
                    end else begin
                        err_n   = 1'b1;
                    end
                end else if (clear) begin
                    state_n = ST_IDLE;
                    cost_n  = 14'd0;
                    err_n   = 1'b0;
                end
            end
            ST_RUN: begin
                if (tick_1hz && (sec_count != SEC_MAX))
                    sec_n = sec_count + 12'd1;
                if (stop) begin
                    state_n = ST_CALC;
                    phase_n = PH_DIV60;
                    work_n  = {5'd0, sec_n};
                    quot_n  = 8'd0;
                end
            end
            ST_CALC: begin
                case (phase)
                    PH_DIV60: begin
                        if (work >= SEC_PER_MIN) begin
                            work_n = work - SEC_PER_MIN;
                            quot_n = quot + 8'd1;
                        end else begin
                            min_n   = cents[6:0];
                            phase_n = PH_MUL;
                        end
                    end
                    PH_MUL: begin
                        prod_n  = {10'd0, min_q} * {9'd0, rate_x100};
                        work_n  = prod_n;
                        quot_n  = 8'd0;
                        phase_n = PH_DIV100;
                    end
                    PH_DIV100: begin
                        if (work >= CENT_DIV) begin
                            work_n = work - CENT_DIV;
                            quot_n = quot + 8'd1;
                        end else begin
                            cost_n  = (14'(cents) > COST_MAX) ? COST_MAX : 14'(cents);
                            state_n = ST_SHOW;
                        end
                    end
                    default: phase_n = PH_DIV60;
                endcase
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase     <= PH_DIV60;
            sec_count <= 12'd0;
            work      <= 17'd0;
            quot      <= 8'd0;
            min_q     <= 7'd0;
            prod      <= 17'd0;
            cost      <= 14'd0;
            hour_err  <= 1'b0;
            loc       <= 3'd0;
            hour      <= 5'd0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            sec_count <= sec_n;
            work      <= work_n;
            quot      <= quot_n;
            min_q     <= min_n;
            prod      <= prod_n;
            cost      <= cost_n;
            hour_err  <= err_n;
            loc       <= loc_n;
            hour      <= hour_n;
        end
    end

endmodule

// File: tb/tb_parking_session_ctrl.sv
// Self-checking bench for parking_session_ctrl: vector table of sessions with a
// scoreboard of expected results, plus hand-written reset/error/restart sequences.
module tb_parking_session_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_1hz = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  sw = 8'd0;
    logic [11:0] sec_count;
    logic [13:0] cost;
    logic        cost_valid;
    logic        running;
    logic        busy;
    logic        hour_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] loc;
        logic [4:0] hour;
        int         ticks;
        bit         stop_tick;
        int         exp_sec;
        int         exp_prod;
        int         exp_cost;
    } vec_t;

    typedef struct {
        int sec;
        int prod;
        int cost;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    parking_session_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .sw         (sw),
        .sec_count  (sec_count),
        .cost       (cost),
        .cost_valid (cost_valid),
        .running    (running),
        .busy       (busy),
        .hour_err   (hour_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " sec_count"}, int'(sec_count), 0);
        chk({name, " cost"}, int'(cost), 0);
        chk({name, " flags"}, int'({cost_valid, running, busy, hour_err}), 0);
    endtask

    task automatic do_start(input logic [2:0] loc, input logic [4:0] hour);
        sw = {loc, hour};
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Waits for cost_valid (bounded), then compares against the scoreboard head.
    task automatic finish_calc(input string name);
        exp_t e;
        int   cnt;
        cnt = 1;
        while (!cost_valid && cnt < 300) begin
            cyc();
            cnt++;
        end
        chk({name, " latency_ok"}, int'(cost_valid && cnt <= 256), 1);
        if (sb.size() == 0) begin
            chk({name, " scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({name, " sec_count"}, int'(sec_count), e.sec);
            chk({name, " cost"}, int'(cost), e.cost);
            chk({name, " prod"}, int'(dut.prod), e.prod);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string name;
        exp_t  e;
        name = $sformatf("vec%0d", idx);
        do_start(v.loc, v.hour);
        chk({name, " running"}, int'(running), 1);
        chk({name, " sec_start"}, int'(sec_count), 0);
        sw = ~sw;
        if (v.ticks > 0) begin
            tick_1hz = 1'b1;
            repeat (v.ticks) cyc();
            tick_1hz = 1'b0;
        end
        stop = 1'b1;
        tick_1hz = v.stop_tick;
        e.sec = v.exp_sec;
        e.prod = v.exp_prod;
        e.cost = v.exp_cost;
        sb.push_back(e);
        cyc();
        stop = 1'b0;
        tick_1hz = 1'b0;
        chk({name, " busy"}, int'(busy), 1);
        finish_calc(name);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk({name, " clr_valid"}, int'(cost_valid), 0);
        chk({name, " clr_cost"}, int'(cost), 0);
        chk({name, " clr_sec_held"}, int'(sec_count), v.exp_sec);
    endtask

    initial begin
        //          loc   hour  ticks stop_tick sec   prod   cost
        vecs[0] = '{3'd0, 5'd9,  125,  1'b0,    125,  501,   6};
        vecs[1] = '{3'd3, 5'd14, 120,  1'b0,    120,  356,   4};
        vecs[2] = '{3'd0, 5'd7,  60,   1'b0,    60,   145,   2};
        vecs[3] = '{3'd0, 5'd8,  60,   1'b0,    60,   167,   2};
        vecs[4] = '{3'd0, 5'd15, 5000, 1'b0,    4095, 13041, 131};
        vecs[5] = '{3'd0, 5'd9,  59,   1'b1,    60,   167,   2};
        vecs[6] = '{3'd5, 5'd20, 61,   1'b0,    61,   312,   4};
        vecs[7] = '{3'd0, 5'd23, 1,    1'b0,    1,    145,   2};
        vecs[8] = '{3'd2, 5'd0,  3600, 1'b0,    3600, 8040,  81};
        vecs[9] = '{3'd0, 5'd12, 0,    1'b0,    0,    0,     0};

        repeat (2) cyc();
        chk_all_zero("reset");
        rst = 1'b0;
        cyc();

        // Invalid hour sets the sticky error; a valid start clears it.
        do_start(3'd0, 5'd25);
        chk("err_set", int'(hour_err), 1);
        chk("err_not_running", int'(running), 0);
        do_start(3'd0, 5'd3);
        chk("err_cleared", int'(hour_err), 0);
        chk("err_then_running", int'(running), 1);
        stop = 1'b1;
        sb.push_back('{sec: 0, prod: 0, cost: 0});
        cyc();
        stop = 1'b0;
        finish_calc("zero_ticks");
        chk("zero_valid", int'(cost_valid), 1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("zero_clr_valid", int'(cost_valid), 0);
        chk("zero_clr_idle", int'({running, busy}), 0);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Reset during RUN.
        do_start(3'd0, 5'd9);
        tick_1hz = 1'b1;
        repeat (30) cyc();
        tick_1hz = 1'b0;
        chk("run30_sec", int'(sec_count), 30);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_all_zero("rst_in_run");

        // Reset mid-CALC.
        do_start(3'd0, 5'd15);
        tick_1hz = 1'b1;
        repeat (4000) cyc();
        tick_1hz = 1'b0;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        repeat (10) cyc();
        chk("calc_busy", int'(busy), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_all_zero("rst_in_calc");

        // Start in SHOW restarts, and start beats a simultaneous clear.
        do_start(3'd1, 5'd10);
        tick_1hz = 1'b1;
        repeat (90) cyc();
        tick_1hz = 1'b0;
        stop = 1'b1;
        sb.push_back('{sec: 90, prod: 312, cost: 4});
        cyc();
        stop = 1'b0;
        finish_calc("show_restart");
        sw = {3'd0, 5'd9};
        start = 1'b1;
        clear = 1'b1;
        cyc();
        start = 1'b0;
        clear = 1'b0;
        chk("restart_running", int'(running), 1);
        chk("restart_valid", int'(cost_valid), 0);
        chk("restart_cost", int'(cost), 0);
        chk("restart_sec", int'(sec_count), 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parking_session_ctrl.md
Name: parking_session_ctrl

Overview:
Session controller for the parking meter. It times a parking session from a 1 Hz tick and captures the location/hour switches at session start. On stop, it sequences a multi-cycle cost computation: seconds to billed minutes, rate lookup, multiply, then cents. It sits between the debounced button/tick logic and the 7-segment display driver, and owns the sec_count and cost values that the display shows.

Parameters:
SEC_MAX, 4095, saturation value of the session second counter (12-bit)
COST_MAX, 9999, clamp value for cost in cents (4-digit display)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick_1hz  in  1  one-cycle pulse, once per second
start  in  1  one-cycle pulse, begin session
stop  in  1  one-cycle pulse, end session
clear  in  1  one-cycle pulse, acknowledge result and return to idle
sw  in  8  sw[7:5] location, sw[4:0] hour (0-23)
sec_count  out  12  elapsed session seconds, live during RUN, frozen after
cost  out  14  session cost in cents, valid when cost_valid=1
cost_valid  out  1  high in SHOW
running  out  1  high in RUN
busy  out  1  high in CALC
hour_err  out  1  sticky; set by start with hour>=24, cleared by next accepted start, clear, or rst

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs are 0; latched location/hour are 0.
- States: IDLE, RUN, CALC, SHOW. CALC has the sub-phases DIV60, MUL, DIV100.
- IDLE:
  - start with sw[4:0]<24: latch sw, zero sec_count, go to RUN next cycle, clear hour_err.
  - start with sw[4:0]>=24: set hour_err, stay in IDLE.
  - stop and clear are ignored.
- RUN:
  - tick_1hz increments sec_count, saturating at SEC_MAX.
  - stop moves to CALC next cycle. A tick in the same cycle as stop is counted.
  - start is ignored. sw changes are ignored (rate is fixed at start).
- CALC/DIV60:
  - Repeated subtraction of 60 from sec_count, one per cycle, giving quotient q and remainder r.
  - min = q + (r != 0), i.e. ceiling division. Zero seconds gives min = 0.
- CALC/MUL:
  - One cycle: prod = min * rate_x100 (17-bit).
- CALC/DIV100:
  - Repeated subtraction of 100 giving cents = ceil(prod/100).
  - cost = min(cents, COST_MAX).
  - Then go to SHOW.
- rate_x100 from the latched location/hour:
  - location 000: hours 0-7 = 145, 8-12 = 167, 13-17 = 189, 18-23 = 145.
  - locations 001-111: hours 0-7 = 134, 8-12 = 156, 13-17 = 178, 18-23 = 156.
- CALC latency: cost_valid is asserted no more than 256 cycles after the stop cycle. busy is high for the whole of CALC. start, stop and clear are ignored during CALC.
- SHOW:
  - cost_valid=1; cost and sec_count are held.
  - clear returns to IDLE next cycle, zeroing cost and cost_valid; sec_count is held until the next start.
  - start in SHOW behaves as IDLE+start: a new session begins directly and cost_valid drops.
  - If start and clear arrive in the same cycle, start wins.
- Reset mid-operation: any state goes to IDLE with all outputs 0 on the cycle after rst is sampled high.
- Width rules: min is at most 69 (7 bits); prod is at most 13041; cost is 14 bits unsigned.

Decomposition:
- Package parking_pkg holds:
  - state and sub-phase encodings
  - SEC_PER_MIN=60 and CENT_DIV=100
  - hour band boundaries 8, 13, 18, 24
  - the eight rate_x100 constants
- Sub-module parking_rate_lut: combinational, location[2:0] and hour[4:0] in, rate_x100[7:0] out. Invalid hour returns 0.

Test Plan:
- loc=000, hour=9, start, 125 ticks, stop -> min=3, prod=501, cost=6, cost_valid=1 within 256 cycles, sec_count=125.
- loc=011, hour=14, 120 ticks, stop; also hour=7 vs hour=8 at loc=000 with 60 ticks -> cost=4; cost=2 (145) vs cost=2 (167); check rate via prod on internal probe.
- start then immediate stop with 0 ticks -> cost=0, cost_valid=1. Then clear -> cost_valid=0, state IDLE.
- loc=000, hour=15, 5000 ticks -> sec_count saturates at 4095, min=69, cost=131.
- start with sw[4:0]=25 -> hour_err=1, running=0. Then start with hour=3 -> hour_err=0, running=1.
- rst asserted in RUN at sec_count=30, and separately mid-CALC -> next cycle all outputs 0, state IDLE. Additionally: stop and tick in the same cycle at sec_count=59 -> sec_count=60, cost for min=1.
